// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, B-type
// target decode, mispredict redirect pulse and a saturating mispredict counter.
module branch_predictor #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_pc_next,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [31:0]      upd_inst,
  input  logic             upd_taken,
  input  logic             upd_pred_taken,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [WIDTH-1:0]   target_q [ENTRIES];
  logic [WIDTH-1:0]   target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];

  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [IDX-1:0]   fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             fetch_hit, upd_hit, mispredict;
  logic [12:0]      imm13;
  logic [WIDTH-1:0] upd_offset, upd_target;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{upd_inst[24:12], upd_inst[6:0]};

  assign fetch_idx = fetch_pc[IDX+1:2];
  assign fetch_tag = fetch_pc[WIDTH-1:IDX+2];
  assign upd_idx   = upd_pc[IDX+1:2];
  assign upd_tag   = upd_pc[WIDTH-1:IDX+2];

  // Prediction reads only registered state, so a same-cycle update is not seen.
  assign fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken   = fetch_hit && cnt_q[fetch_idx][1];
  assign pred_pc_next = pred_taken ? target_q[fetch_idx] : fetch_pc + WIDTH'(4);

  assign imm13      = {upd_inst[31], upd_inst[7], upd_inst[30:25], upd_inst[11:8], 1'b0};
  assign upd_offset = {{(WIDTH-13){imm13[12]}}, imm13};
  assign upd_target = upd_pc + upd_offset;
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict = upd_valid && (upd_taken != upd_pred_taken);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (upd_valid) begin
      if (upd_hit) begin
        target_d[upd_idx] = upd_target;
        if (upd_taken && cnt_q[upd_idx] != 2'd3) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
        end else if (!upd_taken && cnt_q[upd_idx] != 2'd0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        cnt_d[upd_idx]    = 2'd2;
      end
    end
  end

  always_comb begin
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    mis_cnt_d     = mis_cnt_q;
    if (mispredict) begin
      redirect_pc_d = upd_taken ? upd_target : upd_pc + WIDTH'(4);
      if (mis_cnt_q != {CNT_W{1'b1}}) begin
        mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      mis_cnt_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'd1;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = mis_cnt_q;

endmodule
